// File: rtl/BankSramIfPkg.sv
// Shared sizing, types and index helper for the banked-SRAM butterfly read path.
// Build option BSRI_OUT_REG_EN adds a pipe stage after the network and deepens the queue.
package BankSramIfPkg;

  localparam int BW          = 16;
  localparam int NBANK       = 32;
  localparam int XOR_BW      = 4;
  localparam int CB_BW       = 5;
  localparam int CCB_BW      = 3;
  localparam int MAX_ADDR_BW = 15;
  localparam int CLOG2_NDATA = MAX_ADDR_BW - CB_BW;
  localparam int XOR_ADDR_BW = 1 << XOR_BW;

  localparam logic [CB_BW-1:0] BANK_MASK = CB_BW'(NBANK - 1);

`ifdef BSRI_OUT_REG_EN
  localparam int QDEPTH = 3;
`else
  localparam int QDEPTH = 2;
`endif

  typedef logic [NBANK-1:0][BW-1:0] bank_vec_t;

  typedef struct packed {
    logic [CB_BW-1:0][XOR_BW-1:0] xor_src;
    logic [CCB_BW-1:0]            xor_swap;
    logic [CLOG2_NDATA-1:0]       hiaddr;
  } xor_cfg_t;

  function automatic logic [CB_BW-1:0] rotl_idx(
    input logic [CB_BW-1:0] j,
    input int unsigned      s
  );
    return CB_BW'((({j, j} << (s % CB_BW)) >> CB_BW) & BANK_MASK);
  endfunction

endpackage

// File: rtl/bank_sram_butterfly_unperm.sv
// Combinational inverse butterfly/omega network: bank order back to lane order.
// Reusable by any read-path client that stored data with the matching write permutation.
module bank_sram_butterfly_unperm
  import BankSramIfPkg::*;
(
  input  xor_cfg_t                   cfg_i,
  input  logic [NBANK-1:0][BW-1:0]   data_i,
  output logic [NBANK-1:0][BW-1:0]   data_o
);

  always_comb begin
    bank_vec_t              st;
    bank_vec_t              nx;
    logic [XOR_ADDR_BW-1:0] addr;
    st   = data_i;
    nx   = data_i;
    addr = '0;
    for (int k = CCB_BW - 1; k >= 0; k--) begin
      nx = st;
      if (cfg_i.xor_swap[k]) begin
        for (int j = 0; j < NBANK; j++)
          nx[j] = st[rotl_idx(CB_BW'(j), 1 << k)];
      end
      st = nx;
    end
    for (int i = CB_BW - 1; i >= 0; i--) begin
      for (int j = 0; j < NBANK; j++) begin
        addr  = {1'b0, cfg_i.hiaddr, CB_BW'(j)};
        nx[j] = addr[cfg_i.xor_src[i]] ?
                st[CB_BW'(j ^ (1 << i))] : st[j];
      end
      st = nx;
    end
    data_o = st;
  end

endmodule

// File: rtl/bank_sram_butterfly_read_if.sv
// Vector read front-end for banked SRAM: credit-gated issue, inverse permutation, output FIFO.
// BSRI_OUT_REG_EN: registered network output, 3-cycle latency and 3-entry queue.
module bank_sram_butterfly_read_if
  import BankSramIfPkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_rdy,
  output logic                         o_req_ack,
  input  logic [CB_BW-1:0][XOR_BW-1:0] i_xor_src,
  input  logic [CCB_BW-1:0]            i_xor_swap,
  input  logic [CLOG2_NDATA-1:0]       i_hiaddr,
  output logic [NBANK-1:0]             o_sram_re,
  output logic [CLOG2_NDATA-1:0]       o_sram_raddr,
  input  logic [NBANK-1:0][BW-1:0]     i_sram_rdata,
  output logic                         o_data_rdy,
  input  logic                         i_data_ack,
  output logic [NBANK-1:0][BW-1:0]     o_data
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);

  localparam logic [PW-1:0] QLAST = PW'(QDEPTH - 1);

  logic [NBANK-1:0]       re_q;
  logic [CLOG2_NDATA-1:0] raddr_q;
  xor_cfg_t               cfg_q;
  logic                   vld1_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW-1:0]          wr_q, wr_d;
  bank_vec_t              mem_q [QDEPTH];

  logic          acc, push, pop;
  logic [CW-1:0] infl;
  logic [CW:0]   used;
  bank_vec_t     net, push_d;

  bank_sram_butterfly_unperm u_unperm (
    .cfg_i  (cfg_q),
    .data_i (i_sram_rdata),
    .data_o (net)
  );

`ifdef BSRI_OUT_REG_EN
  logic      vld2_q;
  bank_vec_t pipe_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld2_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      vld2_q <= vld1_q;
      pipe_q <= net;
    end
  end

  assign infl   = CW'(vld1_q) + CW'(vld2_q);
  assign push   = vld2_q;
  assign push_d = pipe_q;
`else
  assign infl   = CW'(vld1_q);
  assign push   = vld1_q;
  assign push_d = net;
`endif

  // credit uses the pre-pop count so ack never depends on i_data_ack
  assign used      = (CW+1)'(cnt_q) + (CW+1)'(infl);
  assign o_req_ack = i_rst && (used < (CW+1)'(QDEPTH));
  assign acc       = i_req_rdy && o_req_ack;

  assign o_data_rdy   = (cnt_q != '0);
  assign pop          = o_data_rdy && i_data_ack;
  assign o_data       = o_data_rdy ? mem_q[rd_q] : '0;
  assign o_sram_re    = re_q;
  assign o_sram_raddr = raddr_q;

  function automatic logic [PW-1:0] qnext(
    input logic [PW-1:0] p
  );
    return (p == QLAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) wr_d = qnext(wr_q);
    if (pop)  rd_d = qnext(rd_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      re_q    <= '0;
      raddr_q <= '0;
      cfg_q   <= '0;
      vld1_q  <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      re_q   <= {NBANK{acc}};
      vld1_q <= acc;
      if (acc) begin
        raddr_q <= i_hiaddr;
        cfg_q   <= '{xor_src:  i_xor_src,
                     xor_swap: i_xor_swap,
                     hiaddr:   i_hiaddr};
      end
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= push_d;
  end

  // a stage selecting its own index bit is not a permutation
  always_ff @(posedge i_clk) begin
    if (i_rst && acc) begin
      for (int i = 0; i < CB_BW; i++)
        assert (i_xor_src[i] != XOR_BW'(i));
    end
    if (i_rst && push)
      assert (cnt_q < CW'(QDEPTH));
  end

endmodule
